// File: rtl/int_issue_queue_p_pkg.sv
// Shared types and helpers for the parametrised integer issue queue.
// Covers decoded control, functional-unit classes, ROB age compare and default port capabilities.
package int_issue_queue_p_pkg;

  localparam int ROB_WIDTH = 3;
  localparam int PRF_WIDTH = 6;

  typedef logic [ROB_WIDTH:0]   robid_t;
  typedef logic [PRF_WIDTH-1:0] preg_t;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       is_mul;
    logic       is_jump;
    logic       is_jumpr;
    logic       is_branch;
    logic       rs1_valid;
    logic       rs2_valid;
  } control_type;

  // Enum value doubles as the bit position in a {bju,mul,alu} capability mask
  typedef enum logic [1:0] {
    ALU = 2'd0,
    MUL = 2'd1,
    BJU = 2'd2
  } isq_class_e;

  // Port 0 takes alu+mul, port 1 takes alu+bju
  localparam logic [5:0] DEFAULT_PORT_CAP = 6'b101_011;

  function automatic isq_class_e fu_class(control_type c);
    if (c.is_mul) return MUL;
    if (c.is_jump || c.is_jumpr || c.is_branch) return BJU;
    return ALU;
  endfunction

  // True when a is strictly younger than b, using the ROB wrap bit
  function automatic logic rob_younger(robid_t a, robid_t b);
    if (a[ROB_WIDTH] != b[ROB_WIDTH]) return a[ROB_WIDTH-1:0] < b[ROB_WIDTH-1:0];
    return a[ROB_WIDTH-1:0] > b[ROB_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/int_issue_queue_p_if.sv
// Dispatch, writeback, flush and issue signal bundle of the integer issue queue.
interface int_issue_queue_p_if #(
  parameter int DEPTH = 8,
  parameter int ENQ_W = 2,
  parameter int ISS_W = 2,
  parameter int WB_W  = 4
);
  import int_issue_queue_p_pkg::*;

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ENQ_W-1:0]        enq_valid;
  control_type [ENQ_W-1:0] enq_control;
  logic [ENQ_W-1:0][31:0]  enq_pc;
  robid_t [ENQ_W-1:0]      enq_robid;
  preg_t [ENQ_W-1:0]       enq_src1;
  preg_t [ENQ_W-1:0]       enq_src2;
  preg_t [ENQ_W-1:0]       enq_T;
  logic [ENQ_W-1:0]        enq_src1_busy;
  logic [ENQ_W-1:0]        enq_src2_busy;
  logic [CNT_W-1:0]        free_cnt;

  logic [WB_W-1:0]         wb_valid;
  preg_t [WB_W-1:0]        wb_prd;

  logic                    flush_valid;
  robid_t                  flush_robid;

  logic [ISS_W-1:0]        port_stall;
  logic [ISS_W-1:0]        iss_valid;
  control_type [ISS_W-1:0] iss_control;
  logic [ISS_W-1:0][31:0]  iss_pc;
  robid_t [ISS_W-1:0]      iss_robid;
  preg_t [ISS_W-1:0]       iss_T;
  preg_t [ISS_W-1:0]       iss_src1;
  preg_t [ISS_W-1:0]       iss_src2;

  modport master (
    output enq_valid, enq_control, enq_pc, enq_robid, enq_src1, enq_src2, enq_T,
    output enq_src1_busy, enq_src2_busy, wb_valid, wb_prd, flush_valid, flush_robid,
    output port_stall,
    input  free_cnt, iss_valid, iss_control, iss_pc, iss_robid, iss_T, iss_src1, iss_src2
  );

  modport slave (
    input  enq_valid, enq_control, enq_pc, enq_robid, enq_src1, enq_src2, enq_T,
    input  enq_src1_busy, enq_src2_busy, wb_valid, wb_prd, flush_valid, flush_robid,
    input  port_stall,
    output free_cnt, iss_valid, iss_control, iss_pc, iss_robid, iss_T, iss_src1, iss_src2
  );

endinterface

// File: rtl/int_issue_queue_p_age_picker.sv
// Per-port oldest-ready selection over the age matrix; lower ports choose first.
module isq_age_picker
  import int_issue_queue_p_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int ISS_W = 2,
  parameter logic [3*ISS_W-1:0] PORT_CAP = DEFAULT_PORT_CAP
) (
  input  logic [DEPTH-1:0]             ready,
  input  logic [DEPTH-1:0][2:0]        cls,
  input  logic [DEPTH-1:0][DEPTH-1:0]  older,
  input  logic [ISS_W-1:0]             port_stall,
  output logic [ISS_W-1:0][DEPTH-1:0]  grant,
  output logic [ISS_W-1:0]             iss_valid
);

  always_comb begin : pick
    logic [DEPTH-1:0] taken;
    logic [DEPTH-1:0] cand;
    logic [DEPTH-1:0] col;
    taken = '0;
    for (int p = 0; p < ISS_W; p++) begin
      cand     = '0;
      grant[p] = '0;
      if (!port_stall[p]) begin
        for (int i = 0; i < DEPTH; i++)
          cand[i] = ready[i] && !taken[i] && (|(cls[i] & PORT_CAP[3*p +: 3]));
      end
      // An entry wins when no other candidate is older than it
      for (int i = 0; i < DEPTH; i++) begin
        for (int j = 0; j < DEPTH; j++) col[j] = older[j][i];
        grant[p][i] = cand[i] && !(|(cand & col));
      end
      taken        = taken | grant[p];
      iss_valid[p] = |grant[p];
    end
  end

endmodule

// File: rtl/int_issue_queue_p.sv
// Parametrised out-of-order integer issue queue with age-matrix ordering,
// CDB wakeup (with enqueue bypass), per-port FU capability masks and ROB-based flush.
module int_issue_queue_p
  import int_issue_queue_p_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int ENQ_W = 2,
  parameter int ISS_W = 2,
  parameter int WB_W  = 4,
  parameter logic [3*ISS_W-1:0] PORT_CAP = DEFAULT_PORT_CAP
) (
  input logic               clk,
  input logic               reset_n,
  int_issue_queue_p_if.slave io
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    control_type control;
    logic [31:0] pc;
    robid_t      robid;
    preg_t       src1;
    preg_t       src2;
    preg_t       T;
    logic        busy1;
    logic        busy2;
  } entry_t;

  entry_t                       ent [DEPTH];
  entry_t                       new_ent [ENQ_W];
  logic [DEPTH-1:0]             valid;
  logic [DEPTH-1:0][DEPTH-1:0]  older;
  logic [DEPTH-1:0][DEPTH-1:0]  older_nxt;
  logic [DEPTH-1:0]             ready;
  logic [DEPTH-1:0]             issued;
  logic [DEPTH-1:0]             killed;
  logic [DEPTH-1:0]             wake1;
  logic [DEPTH-1:0]             wake2;
  logic [DEPTH-1:0]             alloc_all;
  logic [DEPTH-1:0][2:0]        cls;
  logic [ENQ_W-1:0][DEPTH-1:0]  alloc_oh;
  logic [ISS_W-1:0][DEPTH-1:0]  grant;
  logic [ISS_W-1:0]             stall_eff;

  function automatic logic woken(preg_t tag, logic [WB_W-1:0] v, preg_t [WB_W-1:0] prd);
    logic hit;
    hit = 1'b0;
    for (int w = 0; w < WB_W; w++)
      if (v[w] && (prd[w] == tag)) hit = 1'b1;
    return hit;
  endfunction

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ready[i]  = valid[i] && (!ent[i].busy1 || !ent[i].control.rs1_valid)
                           && (!ent[i].busy2 || !ent[i].control.rs2_valid);
      cls[i]    = 3'b001 << fu_class(ent[i].control);
      wake1[i]  = woken(ent[i].src1, io.wb_valid, io.wb_prd);
      wake2[i]  = woken(ent[i].src2, io.wb_valid, io.wb_prd);
      killed[i] = io.flush_valid && rob_younger(ent[i].robid, io.flush_robid);
    end
  end

  assign io.free_cnt = CNT_W'(DEPTH - $countones(valid));

  // Flush and reset suppress all issue, which also suppresses deallocation by issue
  assign stall_eff = io.port_stall | {ISS_W{io.flush_valid || !reset_n}};

  isq_age_picker #(
    .DEPTH    (DEPTH),
    .ISS_W    (ISS_W),
    .PORT_CAP (PORT_CAP)
  ) u_picker (
    .ready      (ready),
    .cls        (cls),
    .older      (older),
    .port_stall (stall_eff),
    .grant      (grant),
    .iss_valid  (io.iss_valid)
  );

  always_comb begin
    issued = '0;
    for (int p = 0; p < ISS_W; p++) issued = issued | grant[p];
  end

  always_comb begin : iss_mux
    entry_t sel;
    for (int p = 0; p < ISS_W; p++) begin
      sel = '0;
      for (int i = 0; i < DEPTH; i++)
        if (grant[p][i]) sel = ent[i];
      io.iss_control[p] = sel.control;
      io.iss_pc[p]      = sel.pc;
      io.iss_robid[p]   = sel.robid;
      io.iss_T[p]       = sel.T;
      io.iss_src1[p]    = sel.src1;
      io.iss_src2[p]    = sel.src2;
    end
  end

  // Lanes take the lowest free slots in order; slots freed by this cycle's issue stay unavailable
  always_comb begin : alloc
    logic [DEPTH-1:0] av;
    logic [DEPTH-1:0] all;
    av  = ~valid;
    all = '0;
    for (int k = 0; k < ENQ_W; k++) begin
      alloc_oh[k] = '0;
      if (io.enq_valid[k] && !io.flush_valid) alloc_oh[k] = av & (~av + DEPTH'(1));
      av  = av & ~alloc_oh[k];
      all = all | alloc_oh[k];
    end
    alloc_all = all;
  end

  always_comb begin
    for (int k = 0; k < ENQ_W; k++) begin
      new_ent[k].control = io.enq_control[k];
      new_ent[k].pc      = io.enq_pc[k];
      new_ent[k].robid   = io.enq_robid[k];
      new_ent[k].src1    = io.enq_src1[k];
      new_ent[k].src2    = io.enq_src2[k];
      new_ent[k].T       = io.enq_T[k];
      new_ent[k].busy1   = io.enq_src1_busy[k] && !woken(io.enq_src1[k], io.wb_valid, io.wb_prd);
      new_ent[k].busy2   = io.enq_src2_busy[k] && !woken(io.enq_src2[k], io.wb_valid, io.wb_prd);
    end
  end

  // New rows are older only than later same-cycle lanes; every other row gains the new columns
  always_comb begin : age_next
    logic [DEPTH-1:0] later;
    for (int j = 0; j < DEPTH; j++)
      older_nxt[j] = alloc_all[j] ? older[j] : (older[j] | alloc_all);
    later = '0;
    for (int k = ENQ_W - 1; k >= 0; k--) begin
      for (int i = 0; i < DEPTH; i++)
        if (alloc_oh[k][i]) older_nxt[i] = later;
      later = later | alloc_oh[k];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid <= '0;
      older <= '0;
    end else begin
      valid <= (valid & ~issued & ~killed) | alloc_all;
      older <= older_nxt;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wake1[i]) ent[i].busy1 <= 1'b0;
      if (wake2[i]) ent[i].busy2 <= 1'b0;
      for (int k = 0; k < ENQ_W; k++)
        if (alloc_oh[k][i]) ent[i] <= new_ent[k];
    end
  end

endmodule

// File: tb/tb_int_issue_queue_p.sv
// Directed-vector bench for int_issue_queue_p: per-cycle input/expectation records.
module tb_int_issue_queue_p;
  import int_issue_queue_p_pkg::*;

  logic clk;
  logic reset_n;

  int_issue_queue_p_if #(.DEPTH(8), .ENQ_W(2), .ISS_W(2), .WB_W(4)) io();

  int_issue_queue_p #(.DEPTH(8), .ENQ_W(2), .ISS_W(2), .WB_W(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .io      (io)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic            rst_n;
    logic [1:0]      ev;
    logic [1:0][1:0] k;
    logic [1:0][3:0] r;
    logic [1:0][5:0] s;
    logic [1:0]      b;
    logic [3:0]      wbv;
    logic [5:0]      wbp;
    logic            fl;
    logic [3:0]      frob;
    logic [1:0]      stall;
    logic [1:0]      xiv;
    logic [1:0][3:0] xr;
    logic [3:0]      xfree;
  } vec_t;

  vec_t tbl[$];
  int   chk = 0;
  int   err = 0;
  int   vno = 0;

  function automatic vec_t mk(int rst, int ev, int k0, int r0, int s0, int b0,
                              int k1, int r1, int s1, int b1, int wbv, int wbp,
                              int fl, int frob, int st, int xiv, int xr0, int xr1, int xfree);
    vec_t v;
    v.rst_n = 1'(rst);  v.ev = 2'(ev);
    v.k[0] = 2'(k0); v.r[0] = 4'(r0); v.s[0] = 6'(s0); v.b[0] = 1'(b0);
    v.k[1] = 2'(k1); v.r[1] = 4'(r1); v.s[1] = 6'(s1); v.b[1] = 1'(b1);
    v.wbv = 4'(wbv); v.wbp = 6'(wbp);
    v.fl = 1'(fl); v.frob = 4'(frob); v.stall = 2'(st);
    v.xiv = 2'(xiv); v.xr[0] = 4'(xr0); v.xr[1] = 4'(xr1); v.xfree = 4'(xfree);
    return v;
  endfunction

  // kind: 0 alu, 1 mul, 2 bju (branch)
  function automatic control_type ctl(logic [1:0] kind);
    control_type c;
    c = '0;
    c.alu_op    = 4'h3;
    c.rs1_valid = 1'b1;
    c.rs2_valid = 1'b1;
    c.is_mul    = (kind == 2'd1);
    c.is_branch = (kind == 2'd2);
    return c;
  endfunction

  task automatic drive(input vec_t v);
    reset_n = v.rst_n;
    io.enq_valid = v.ev;
    for (int k = 0; k < 2; k++) begin
      io.enq_control[k]   = ctl(v.k[k]);
      io.enq_pc[k]        = 32'h1000 + {26'd0, v.r[k], 2'b00};
      io.enq_robid[k]     = v.r[k];
      io.enq_src1[k]      = v.s[k];
      io.enq_src2[k]      = 6'd0;
      io.enq_T[k]         = {2'b10, v.r[k]};
      io.enq_src1_busy[k] = v.b[k];
      io.enq_src2_busy[k] = 1'b0;
    end
    io.wb_valid = v.wbv;
    for (int w = 0; w < 4; w++) io.wb_prd[w] = v.wbp;
    io.flush_valid = v.fl;
    io.flush_robid = v.frob;
    io.port_stall  = v.stall;
  endtask

  task automatic check(input vec_t v);
    chk++;
    if (io.free_cnt !== v.xfree) begin
      err++;
      $display("FAIL free_cnt vec %0d got %0d want %0d", vno, io.free_cnt, v.xfree);
    end
    chk++;
    if (io.iss_valid !== v.xiv) begin
      err++;
      $display("FAIL iss_valid vec %0d got %b want %b", vno, io.iss_valid, v.xiv);
    end
    for (int p = 0; p < 2; p++) begin
      if (v.xiv[p]) begin
        chk++;
        if (io.iss_robid[p] !== v.xr[p]) begin
          err++;
          $display("FAIL iss_robid[%0d] vec %0d got %0d want %0d", p, vno, io.iss_robid[p], v.xr[p]);
        end
        chk++;
        if ({io.iss_pc[p], io.iss_T[p]} !== {32'h1000 + {26'd0, v.xr[p], 2'b00}, 2'b10, v.xr[p]}) begin
          err++;
          $display("FAIL iss_payload[%0d] vec %0d got pc %h T %0d want robid %0d payload",
                   p, vno, io.iss_pc[p], io.iss_T[p], v.xr[p]);
        end
      end
    end
  endtask

  task automatic step(input vec_t v);
    @(posedge clk);
    #1;
    drive(v);
    @(negedge clk);
    check(v);
    vno++;
  endtask

  always @(posedge clk) begin
    if (reset_n) begin
      for (int k = 0; k < 2; k++)
        assert (!(io.enq_valid[k] && (io.free_cnt <= k)))
          else $error("enqueue on lane %0d without room", k);
    end
  end

  initial begin
    //            rst ev k0 r0 s0 b0  k1 r1 s1 b1  wbv wbp fl fr st  xiv xr0 xr1 free
    // reset state, then two ready ALU ops issue on both ports
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0,  0, 0, 0,  0, 0, 0, 8));
    tbl.push_back(mk(1, 3, 0, 0, 0, 0,  0, 1, 0, 0,  0, 0,  0, 0, 0,  0, 0, 0, 8));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0,  0, 0, 0,  3, 0, 1, 6));
    // enqueue bypass: p9 woken in the enqueue cycle
    tbl.push_back(mk(1, 1, 0, 2, 9, 1,  0, 0, 0, 0,  1, 9,  0, 0, 0,  0, 0, 0, 8));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0,  0, 0, 0,  1, 2, 0, 7));
    // busy source waits for its wakeup, then issues one cycle later
    tbl.push_back(mk(1, 1, 0, 3,10, 1,  0, 0, 0, 0,  0, 0,  0, 0, 0,  0, 0, 0, 8));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0,  0, 0, 0,  0, 0, 0, 7));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0,  8,10,  0, 0, 0,  0, 0, 0, 7));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0,  0, 0, 0,  1, 3, 0, 7));
    // older BJU with port1 stalled: port0 takes the ALU, BJU waits for port1
    tbl.push_back(mk(1, 3, 2, 4, 0, 0,  0, 5, 0, 0,  0, 0,  0, 0, 0,  0, 0, 0, 8));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0,  0, 0, 2,  1, 5, 0, 6));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0,  0, 0, 0,  2, 0, 4, 7));
    // age beats index: robid 7 in slot 1 is older than robid 8 reusing slot 0
    tbl.push_back(mk(1, 3, 0, 6, 0, 0,  0, 7,12, 1,  0, 0,  0, 0, 0,  0, 0, 0, 8));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0,  0, 0, 0,  1, 6, 0, 6));
    tbl.push_back(mk(1, 1, 0, 8, 0, 0,  0, 0, 0, 0,  2,12,  0, 0, 0,  0, 0, 0, 7));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0,  0, 0, 0,  3, 7, 8, 6));
    // flush at robid 7 kills 8 (wrapped) and 9, drops the enqueue, blocks issue
    tbl.push_back(mk(1, 3, 0, 6,20, 1,  0, 7,20, 1,  0, 0,  0, 0, 0,  0, 0, 0, 8));
    tbl.push_back(mk(1, 3, 0, 8,21, 1,  0, 9,21, 1,  1,20,  0, 0, 0,  0, 0, 0, 6));
    tbl.push_back(mk(1, 1, 0,10, 0, 0,  0, 0, 0, 0,  2,21,  1, 7, 0,  0, 0, 0, 4));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0,  0, 0, 0,  3, 6, 7, 6));

    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8));
    repeat (2) @(posedge clk);

    foreach (tbl[i]) step(tbl[i]);

    // Fill all eight slots with MUL ops waiting on p5
    for (int b = 0; b < 4; b++)
      step(mk(1, 3, 1, 2*b, 5, 1, 1, 2*b+1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 8 - 2*b));
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 5, 0, 0, 0, 0, 0, 0, 0));
    // Only port0 can take MUL: one per cycle, oldest first, port1 idle
    for (int r = 0; r < 3; r++)
      step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, r, 0, r));
    // Reset with five ready entries resident
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3));
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8));

    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule
